// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared states, source codes, vector defaults and P bit helpers
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_PCH = 3'd1,
    ST_PUSH_PCL = 3'd2,
    ST_PUSH_P   = 3'd3,
    ST_VEC_LO   = 3'd4,
    ST_VEC_HI   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_BRK = 2'd2,
    SRC_IRQ = 2'd3
  } src_t;

  localparam logic [15:0] VEC_NMI_DEF    = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

  localparam int P_BIT_I = 2;
  localparam int P_BIT_B = 4;
  localparam int P_BIT_U = 5;

  // Stacked P: unused bit always reads 1, B marks a software (BRK) entry.
  function automatic logic [7:0] push_psr(input logic [7:0] psr, input logic is_brk);
    logic [7:0] p;
    p          = psr;
    p[P_BIT_U] = 1'b1;
    p[P_BIT_B] = is_brk;
    return p;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - memory bus between the interrupt sequencer and system memory
interface interrupt_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// rtl/interrupt_sequencer_nmi_edge_detect.sv - NMI falling-edge detector with pending latch
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_x,
  input  logic i_nmi_x,
  input  logic i_clr,
  output logic o_pend
);
  logic r_prev;
  logic r_pend;

  // Previous pin sample idles high; a new edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_prev <= 1'b1;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_nmi_x;
      r_pend <= (r_pend & ~i_clr) | (r_prev & ~i_nmi_x);
    end
  end

  assign o_pend = r_pend;
endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - RESET/NMI/IRQ/BRK entry sequencer; optional INTR_NMI_HIJACK_EN
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] VEC_NMI    = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST    = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ    = VEC_IRQ_DEF,
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF
) (
  input  logic                         clk,
  input  logic                         rst_x,
  input  logic                         nmi_x,
  input  logic                         irq_x,
  input  logic                         brk_req,
  input  logic                         mc_sync,
  input  logic [15:0]                  rf_pc,
  input  logic [7:0]                   rf_psr,
  input  logic [7:0]                   rf_s,
  interrupt_sequencer_if.master        bus,
  output logic [7:0]                   intr_data,
  output logic                         intr_set_pcl,
  output logic                         intr_set_pch,
  output logic                         intr_pushed,
  output logic                         intr_set_i,
  output logic                         intr_set_b,
  output logic                         intr_busy,
  output logic                         intr_done
);

  state_t      r_state;
  state_t      w_next;
  src_t        r_src;
  logic [15:0] r_vec;
  logic        r_rst_pend;
  logic        r_brk_pend;

  logic w_idle, w_brk_any, w_nmi_pend, w_nmi_clr, w_hijack;
  logic w_accept_rst, w_accept_nmi, w_accept_brk, w_accept_irq, w_accept_any;

  nmi_edge_detect u_nmi (
    .clk     (clk),
    .rst_x   (rst_x),
    .i_nmi_x (nmi_x),
    .i_clr   (w_nmi_clr),
    .o_pend  (w_nmi_pend)
  );

  assign w_idle       = (r_state == ST_IDLE);
  assign w_brk_any    = r_brk_pend | brk_req;
  assign w_accept_rst = w_idle & r_rst_pend;
  assign w_accept_nmi = w_idle & ~r_rst_pend & mc_sync & w_nmi_pend;
  assign w_accept_brk = w_idle & ~r_rst_pend & mc_sync & ~w_nmi_pend & w_brk_any;
  assign w_accept_irq = w_idle & ~r_rst_pend & mc_sync & ~w_nmi_pend & ~w_brk_any
                      & ~irq_x & ~rf_psr[P_BIT_I];
  assign w_accept_any = w_accept_rst | w_accept_nmi | w_accept_brk | w_accept_irq;

`ifdef INTR_NMI_HIJACK_EN
  // A pending NMI redirects a maskable entry while the vector has not been fetched yet.
  assign w_hijack = (r_state == ST_PUSH_P) & bus.mem_ack & w_nmi_pend
                  & ((r_src == SRC_IRQ) | (r_src == SRC_BRK));
`else
  assign w_hijack = 1'b0;
`endif

  assign w_nmi_clr = w_accept_nmi | w_hijack;

  // State register; reset forces IDLE and aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Sequence context: pending requests, accepted source and vector address.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_rst_pend <= 1'b1;
      r_brk_pend <= 1'b0;
      r_src      <= SRC_RST;
      r_vec      <= VEC_RST;
    end else begin
      if (w_accept_rst) r_rst_pend <= 1'b0;
      r_brk_pend <= w_brk_any & ~w_accept_brk;
      if (w_accept_rst) begin
        r_src <= SRC_RST;
        r_vec <= VEC_RST;
      end else if (w_accept_nmi) begin
        r_src <= SRC_NMI;
        r_vec <= VEC_NMI;
      end else if (w_accept_brk) begin
        r_src <= SRC_BRK;
        r_vec <= VEC_IRQ;
      end else if (w_accept_irq) begin
        r_src <= SRC_IRQ;
        r_vec <= VEC_IRQ;
      end else if (w_hijack) begin
        r_vec <= VEC_NMI;
      end
    end
  end

  // Next state and bus/RegisterFile strobes; each bus state holds its request until acked.
  always_comb begin
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 8'h00;
    intr_data     = 8'h00;
    intr_set_pcl  = 1'b0;
    intr_set_pch  = 1'b0;
    intr_pushed   = 1'b0;
    intr_set_i    = 1'b0;
    intr_set_b    = 1'b0;
    intr_busy     = (r_state != ST_IDLE);
    intr_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept_rst)      w_next = ST_VEC_LO;
        else if (w_accept_any) w_next = ST_PUSH_PCH;
      end
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {STACK_PAGE, rf_s};
        if (r_state == ST_PUSH_PCH)      bus.mem_wdata = rf_pc[15:8];
        else if (r_state == ST_PUSH_PCL) bus.mem_wdata = rf_pc[7:0];
        else                             bus.mem_wdata = push_psr(rf_psr, r_src == SRC_BRK);
        if (bus.mem_ack) begin
          intr_pushed = 1'b1;
          if (r_state == ST_PUSH_PCH)      w_next = ST_PUSH_PCL;
          else if (r_state == ST_PUSH_PCL) w_next = ST_PUSH_P;
          else begin
            intr_set_b = (r_src == SRC_BRK);
            w_next     = ST_VEC_LO;
          end
        end
      end
      ST_VEC_LO: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = r_vec;
        if (bus.mem_ack) begin
          intr_data    = bus.mem_rdata;
          intr_set_pcl = 1'b1;
          intr_set_i   = 1'b1;
          w_next       = ST_VEC_HI;
        end
      end
      ST_VEC_HI: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = r_vec + 16'd1;
        if (bus.mem_ack) begin
          intr_data    = bus.mem_rdata;
          intr_set_pch = 1'b1;
          w_next       = ST_DONE;
        end
      end
      ST_DONE: begin
        intr_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst_x, nmi_x, irq_x, brk_req, mc_sync;
  logic [15:0] rf_pc;
  logic [7:0]  rf_psr, rf_s;
  logic [7:0]  intr_data;
  logic        intr_set_pcl, intr_set_pch, intr_pushed, intr_set_i, intr_set_b, intr_busy, intr_done;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk          (clk),
    .rst_x        (rst_x),
    .nmi_x        (nmi_x),
    .irq_x        (irq_x),
    .brk_req      (brk_req),
    .mc_sync      (mc_sync),
    .rf_pc        (rf_pc),
    .rf_psr       (rf_psr),
    .rf_s         (rf_s),
    .bus          (bus),
    .intr_data    (intr_data),
    .intr_set_pcl (intr_set_pcl),
    .intr_set_pch (intr_set_pch),
    .intr_pushed  (intr_pushed),
    .intr_set_i   (intr_set_i),
    .intr_set_b   (intr_set_b),
    .intr_busy    (intr_busy),
    .intr_done    (intr_done)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } xact_t;

  xact_t exp_q[$];
  xact_t mon_e;
  int    errors = 0;
  int    checks = 0;
  int    pushed_cnt = 0;
  int    setb_cnt = 0;
  int    done_cnt = 0;
  int    lat = 0;
  int    wait_cnt = 0;
  int    done_target = 0;
  logic  req_seen = 1'b0;
  logic  busy_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rom(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'hA0;
      16'hFFFC: return 8'h00;
      16'hFFFD: return 8'h80;
      16'hFFFE: return 8'h00;
      16'hFFFF: return 8'h90;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic expect_rd(input logic [15:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: done=%0d required %0d", name, done_cnt, target);
    end
    repeat (3) begin @(negedge clk); #3; end
  endtask

  task automatic wait_push(input logic [15:0] a, input string name);
    int n = 0;
    while (!(bus.mem_req && bus.mem_we && bus.mem_addr == a) && n < 60) begin
      @(negedge clk); #3;
      n++;
    end
    check({name, "_reached"}, {31'd0, bus.mem_req && bus.mem_we && bus.mem_addr == a}, 32'd1);
  endtask

  function automatic logic [31:0] out_or();
    return {31'd0, |{bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, intr_data,
                     intr_set_pcl, intr_set_pch, intr_pushed, intr_set_i, intr_set_b,
                     intr_busy, intr_done}};
  endfunction

  // Memory responder: ack each request after lat idle cycles, vector bytes from rom().
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      if (bus.mem_req === 1'b1) begin
        if (wait_cnt == 0) begin
          bus.mem_ack = 1'b1;
          if (!bus.mem_we) bus.mem_rdata = rom(bus.mem_addr);
          wait_cnt = lat;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: scoreboard pop on every completed transfer, RegisterFile model updates.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (bus.mem_req) req_seen = 1'b1;
      if (intr_busy) busy_seen = 1'b1;
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h required no transfer",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("bus_we", {31'd0, bus.mem_we}, {31'd0, mon_e.we});
          check("bus_addr", {16'd0, bus.mem_addr}, {16'd0, mon_e.addr});
          if (mon_e.we) check("bus_wdata", {24'd0, bus.mem_wdata}, {24'd0, mon_e.data});
        end
      end
      if (intr_pushed) begin
        pushed_cnt++;
        rf_s = rf_s - 8'd1;
      end
      if (intr_set_pcl) rf_pc[7:0] = intr_data;
      if (intr_set_pch) rf_pc[15:8] = intr_data;
      if (intr_set_i) rf_psr[2] = 1'b1;
      if (intr_set_b) setb_cnt++;
      if (intr_done) done_cnt++;
    end
  end

  initial begin
    rst_x = 1'b0; nmi_x = 1'b1; irq_x = 1'b1; brk_req = 1'b0; mc_sync = 1'b0;
    rf_pc = 16'h0000; rf_psr = 8'h00; rf_s = 8'hFD;
    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs", out_or(), 32'd0);

    // RESET entry: no pushes, vector $FFFC/$FFFD
    expect_rd(16'hFFFC);
    expect_rd(16'hFFFD);
    @(negedge clk); rst_x = 1'b1;
    wait_done(1, 50, "t1");
    check("t1_pc", {16'd0, rf_pc}, 32'h8000);
    check("t1_pushed", pushed_cnt, 0);
    check("t1_done", done_cnt, 1);
    check("t1_i_flag", {31'd0, rf_psr[2]}, 32'd1);
    check("t1_queue", exp_q.size(), 0);

    // IRQ entry from PC=$1234, S=$FD, P=$00
    lat = 1; rf_pc = 16'h1234; rf_s = 8'hFD; rf_psr = 8'h00; pushed_cnt = 0;
    expect_wr(16'h01FD, 8'h12);
    expect_wr(16'h01FC, 8'h34);
    expect_wr(16'h01FB, 8'h20);
    expect_rd(16'hFFFE);
    expect_rd(16'hFFFF);
    irq_x = 1'b0; mc_sync = 1'b1;
    @(negedge clk); #3; mc_sync = 1'b0;
    wait_done(2, 80, "t2");
    irq_x = 1'b1;
    check("t2_pc", {16'd0, rf_pc}, 32'h9000);
    check("t2_pushed", pushed_cnt, 3);
    check("t2_s", {24'd0, rf_s}, 32'hFA);
    check("t2_queue", exp_q.size(), 0);

    // Masked IRQ: I=1 with irq_x low must never start a sequence
    rf_psr = 8'h04; req_seen = 1'b0; busy_seen = 1'b0;
    irq_x = 1'b0; mc_sync = 1'b1;
    repeat (20) begin @(negedge clk); #3; end
    mc_sync = 1'b0; irq_x = 1'b1;
    check("t3_mem_req", {31'd0, req_seen}, 32'd0);
    check("t3_busy", {31'd0, busy_seen}, 32'd0);
    check("t3_done", done_cnt, 2);

    // BRK with P=$01 pushes $31 and pulses intr_set_b once
    lat = 0; rf_pc = 16'h2000; rf_s = 8'hFD; rf_psr = 8'h01; pushed_cnt = 0; setb_cnt = 0;
    expect_wr(16'h01FD, 8'h20);
    expect_wr(16'h01FC, 8'h00);
    expect_wr(16'h01FB, 8'h31);
    expect_rd(16'hFFFE);
    expect_rd(16'hFFFF);
    brk_req = 1'b1; mc_sync = 1'b1;
    @(negedge clk); #3; brk_req = 1'b0; mc_sync = 1'b0;
    wait_done(3, 80, "t4");
    check("t4_set_b", setb_cnt, 1);
    check("t4_pc", {16'd0, rf_pc}, 32'h9000);
    check("t4_pushed", pushed_cnt, 3);
    check("t4_queue", exp_q.size(), 0);

    // NMI edge during IRQ PUSH_PCL
    lat = 3; rf_pc = 16'h4321; rf_s = 8'hFD; rf_psr = 8'h00; setb_cnt = 0;
    expect_wr(16'h01FD, 8'h43);
    expect_wr(16'h01FC, 8'h21);
    expect_wr(16'h01FB, 8'h20);
`ifdef INTR_NMI_HIJACK_EN
    expect_rd(16'hFFFA);
    expect_rd(16'hFFFB);
    done_target = 4;
`else
    expect_rd(16'hFFFE);
    expect_rd(16'hFFFF);
    expect_wr(16'h01FA, 8'h90);
    expect_wr(16'h01F9, 8'h00);
    expect_wr(16'h01F8, 8'h24);
    expect_rd(16'hFFFA);
    expect_rd(16'hFFFB);
    done_target = 5;
`endif
    irq_x = 1'b0; mc_sync = 1'b1;
    wait_push(16'h01FC, "t5_push_pcl");
    nmi_x = 1'b0;
    wait_done(done_target, 200, "t5");
    repeat (5) begin @(negedge clk); #3; end
    mc_sync = 1'b0; irq_x = 1'b1; nmi_x = 1'b1;
    check("t5_pc", {16'd0, rf_pc}, 32'hA000);
    check("t5_done", done_cnt, done_target);
    check("t5_set_b", setb_cnt, 0);
    check("t5_queue", exp_q.size(), 0);

    // Reset asserted during PUSH_P aborts, then RESET entry reruns
    lat = 3; rf_pc = 16'h5555; rf_s = 8'hFD; rf_psr = 8'h00; pushed_cnt = 0;
    expect_wr(16'h01FD, 8'h55);
    expect_wr(16'h01FC, 8'h55);
    expect_rd(16'hFFFC);
    expect_rd(16'hFFFD);
    irq_x = 1'b0; mc_sync = 1'b1;
    wait_push(16'h01FB, "t6_push_p");
    rst_x = 1'b0;
    #1;
    check("t6_abort_outputs", out_or(), 32'd0);
    mc_sync = 1'b0; irq_x = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    rst_x = 1'b1;
    wait_done(done_target + 1, 80, "t6");
    check("t6_pc", {16'd0, rf_pc}, 32'h8000);
    check("t6_pushed", pushed_cnt, 2);
    check("t6_done", done_cnt, done_target + 1);
    check("t6_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
